// File: rtl/seq_mul_if.sv
// Operand/product handshake bundle for seq_mul: valid/ready on the operand side and on the product side.
interface seq_mul_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] prod;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, prod, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, prod, out_valid
    );
endinterface

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, one partial product per cycle, unsigned or two's-complement.
// Optional SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mul #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    seq_mul_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [PW-1:0]    acc, acc_n;
    logic [PW-1:0]    prod, prod_n;
    logic [PW-1:0]    addend, acc_sum;
    logic [CW-1:0]    count, count_n;
    logic             sign, sign_n;
    logic             out_valid, out_valid_n;
    logic             a_neg, b_neg;
    logic             term_early;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            prod      <= '0;
            count     <= '0;
            sign      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            mcand     <= mcand_n;
            mplier    <= mplier_n;
            acc       <= acc_n;
            prod      <= prod_n;
            count     <= count_n;
            sign      <= sign_n;
            out_valid <= out_valid_n;
        end
    end

    // Operands are stored as magnitudes so the core loop is always unsigned;
    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
    always_comb begin
        state_n     = state;
        mcand_n     = mcand;
        mplier_n    = mplier;
        acc_n       = acc;
        prod_n      = prod;
        count_n     = count;
        sign_n      = sign;
        out_valid_n = out_valid;

        a_neg   = SIGNED && bus.a[WIDTH-1];
        b_neg   = SIGNED && bus.b[WIDTH-1];
        addend  = PW'(mcand) << count;
        acc_sum = mplier[0] ? acc + addend : acc;
`ifdef SEQ_MUL_EARLY_TERM_EN
        term_early = (mplier == '0);
`else
        term_early = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_n  = a_neg ? -bus.a : bus.a;
                    mplier_n = b_neg ? -bus.b : bus.b;
                    sign_n   = a_neg ^ b_neg;
                    acc_n    = '0;
                    count_n  = '0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                if (term_early) begin
                    prod_n      = sign ? -acc : acc;
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    acc_n    = acc_sum;
                    mplier_n = mplier >> 1;
                    count_n  = count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        prod_n      = sign ? -acc_sum : acc_sum;
                        out_valid_n = 1'b1;
                        state_n     = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.prod      = prod;
    assign bus.out_valid = out_valid;
endmodule
